// File: rtl/store_buffer.sv
// Store buffer that sits in front of a single-port data memory.
// Stores are queued and drained in order, one per cycle. Loads win the memory
// port, and a load takes its data from the youngest queued store to the same word.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_resp_valid,
  output logic [DATA_W-1:0]        ld_resp_data,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              resp_valid_reg;
  logic [DATA_W-1:0] resp_data_reg;

  logic              full, st_fire, ld_fire, drain_fire;
  logic [DEPTH-1:0]  hit;
  logic [PTR_W-1:0]  scan_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] load_data_next;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign st_ready   = !full;
  assign ld_ready   = !full;
  assign st_fire    = st_valid && st_ready;
  assign ld_fire    = ld_valid && ld_ready;
  assign drain_fire = !ld_fire && (count_reg != '0);

  assign sb_count      = count_reg;
  assign sb_empty      = (count_reg == '0);
  assign ld_resp_valid = resp_valid_reg;
  assign ld_resp_data  = resp_data_reg;

  // Per physical slot: is it occupied, and does it hold the load's word?
  // A slot is occupied when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] age;
    assign age     = PTR_W'(gi) - head_reg;
    assign hit[gi] = ({1'b0, age} < count_reg) &&
                     (addr_mem[gi][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
  end

  // Scan from oldest to youngest so the last hit seen is the youngest match.
  always_comb begin
    scan_idx = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_reg + PTR_W'(i);
      if (hit[scan_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[scan_idx];
      end
    end
  end

  assign load_data_next = fwd_hit ? fwd_data : mem_rdata;

  // Memory port arbitration: a load owns the port, otherwise drain the head entry.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_fire) begin
      mem_read = 1'b1;
      mem_addr = ld_addr;
    end else if (drain_fire) begin
      mem_write = 1'b1;
      mem_addr  = addr_mem[head_reg];
      mem_wdata = data_mem[head_reg];
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (st_fire) begin
      addr_mem[tail_reg] <= st_addr;
      data_mem[tail_reg] <= st_data;
    end
  end

  // Pointers, occupancy and the registered load response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      if (st_fire)    tail_reg <= tail_reg + 1'b1;
      if (drain_fire) head_reg <= head_reg + 1'b1;
      count_reg      <= count_reg + CNT_W'(st_fire) - CNT_W'(drain_fire);
      resp_valid_reg <= ld_fire;
      if (ld_fire) resp_data_reg <= load_data_next;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based model of the buffer and memory.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (written by its drains) and the model's own image.
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = env_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) env_mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } entry_t;
  entry_t      model_q [$];
  logic        exp_resp_valid;
  logic [31:0] exp_resp_data;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check port outputs, advance the model.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la);
    int          cnt;
    logic        full, s_fire, l_fire, drain;
    logic [31:0] ld_val;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    #1;
    cnt    = model_q.size();
    full   = (cnt == DEPTH);
    s_fire = sv && !full;
    l_fire = lv && !full;
    drain  = !l_fire && cnt > 0;
    check_val("st_ready", 32'(st_ready), 32'(!full));
    check_val("ld_ready", 32'(ld_ready), 32'(!full));
    check_val("sb_count", 32'(sb_count), 32'(cnt));
    check_val("sb_empty", 32'(sb_empty), 32'(cnt == 0));
    check_val("mem_read", 32'(mem_read), 32'(l_fire));
    check_val("mem_write", 32'(mem_write), 32'(drain));
    check_val("mem_addr", mem_addr, l_fire ? la : (drain ? model_q[0].a : 32'h0));
    check_val("mem_wdata", mem_wdata, drain ? model_q[0].d : 32'h0);
    // Load value: youngest buffered store to the same word, else memory.
    ld_val = ref_mem[la[9:2]];
    foreach (model_q[i]) if (model_q[i].a[31:2] == la[31:2]) ld_val = model_q[i].d;
    @(posedge clk);
    if (drain) begin
      ref_mem[model_q[0].a[9:2]] = model_q[0].d;
      void'(model_q.pop_front());
    end
    if (s_fire) model_q.push_back('{a: sa, d: sd});
    exp_resp_valid = l_fire;
    if (l_fire) exp_resp_data = ld_val;
    @(negedge clk);
    check_val("ld_resp_valid", 32'(ld_resp_valid), 32'(exp_resp_valid));
    check_val("ld_resp_data", ld_resp_data, exp_resp_data);
    $display("cyc st=%b %h=%h ld=%b %h wr=%b rd=%b cnt=%0d resp=%b %h",
             sv, sa, sd, lv, la, drain, l_fire, model_q.size(), ld_resp_valid, ld_resp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset applied away from the clock edge; effects must be immediate.
  task automatic do_reset();
    st_valid = 1'b0; ld_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0;
    reset = 1'b1;
    #1;
    model_q.delete();
    exp_resp_valid = 1'b0;
    exp_resp_data  = 32'h0;
    check_val("rst_sb_count", 32'(sb_count), 32'h0);
    check_val("rst_sb_empty", 32'(sb_empty), 32'h1);
    check_val("rst_resp_valid", 32'(ld_resp_valid), 32'h0);
    check_val("rst_resp_data", ld_resp_data, 32'h0);
    check_val("rst_mem_write", 32'(mem_write), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset applied, buffer cleared");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    env_mem[8'h20] = 32'hDEADBEEF; ref_mem[8'h20] = 32'hDEADBEEF;  // 0x80
    env_mem[8'h18] = 32'h9;        ref_mem[8'h18] = 32'h9;         // 0x60
    exp_resp_valid = 1'b0;
    exp_resp_data  = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    do_reset();

    // In-order drain of three stores.
    step(1'b1, 32'h100, 32'hAAAA0001, 1'b0, 32'h0);
    step(1'b1, 32'h104, 32'hAAAA0002, 1'b0, 32'h0);
    step(1'b1, 32'h108, 32'hAAAA0003, 1'b0, 32'h0);
    idle(3);

    // Fill while loads block drain; full buffer stalls the load and drains.
    for (int k = 0; k < 5; k++) step(1'b1, 32'h10 + 32'(4 * k), 32'hB0 + 32'(k), 1'b1, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
    idle(4);

    // Forwarding from the youngest of two stores to the same word.
    step(1'b1, 32'h40, 32'h11, 1'b1, 32'h200);
    step(1'b1, 32'h40, 32'h22, 1'b1, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h42);
    idle(3);

    // Miss from an empty buffer.
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h80);
    idle(1);

    // Same-cycle store and load: the load must see the old memory value.
    step(1'b1, 32'h60, 32'h5, 1'b1, 32'h60);
    idle(1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h60);

    // Pointer wrap with interleaved drains.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h140 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 1'b0, 32'h0);
      idle(1);
    end

    // Reset with two buffered stores and a pending load response.
    step(1'b1, 32'h180, 32'h1, 1'b1, 32'h300);
    step(1'b1, 32'h184, 32'h2, 1'b1, 32'h300);
    do_reset();
    idle(2);

    // Random traffic over a small address window to provoke forwarding hits.
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
           1'($urandom_range(0, 3) == 0), 32'($urandom_range(0, 63)));
    end
    idle(DEPTH + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
